// File: rtl/div_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : div_sched_pkg
//  Description : Shared constants and types for the divide sequencer:
//                operand width, op encodings, FSM state encodings and small
//                op-decoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_sched_pkg;

    localparam int CORE_W = 32;

    // EX-stage divide op encodings (bit 1 = unsigned, bit 0 = remainder)
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_MOD  = 2'b01;
    localparam logic [1:0] DIV_OP_DIVU = 2'b10;
    localparam logic [1:0] DIV_OP_MODU = 2'b11;

    // Sequencer states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Per-request context kept while the core works on the magnitudes
    typedef struct packed {
        logic [1:0] op;
        logic       neg_q;
        logic       neg_r;
    } div_ctx_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_MOD);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_MOD) || (op == DIV_OP_MODU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : div_sign_fix
//  Description : Combinational sign fix-up of the unsigned core result and
//                selection of quotient or remainder for the requested op.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] core_res,
    input  logic           neg_q,
    input  logic           neg_r,
    input  logic [1:0]     op,
    output logic [W-1:0]   resp_data
);
    import div_sched_pkg::*;

    logic [W-1:0] w_quo;
    logic [W-1:0] w_rem;

    assign w_quo = core_res[2*W-1:W];
    assign w_rem = core_res[W-1:0];

    // Negate the selected half when its sign flag is set (mod 2^W)
    always_comb begin
        if (op_is_rem(op)) begin
            resp_data = neg_r ? -w_rem : w_rem;
        end else begin
            resp_data = neg_q ? -w_quo : w_quo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : div_sched
//  Description : Shares one unsigned AXI-stream divider core among the
//                div.w / mod.w / div.wu / mod.wu ops. Converts signed
//                operands to magnitudes, issues them to the core, fixes up
//                the signs of the result and returns it over valid/ready.
//                A flush while a divide is in flight drains and discards the
//                core result, since the core cannot be cancelled.
//                Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the
//                core and answers quotient all-ones / remainder = src1.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sched #(
    parameter int CORE_W = div_sched_pkg::CORE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [CORE_W-1:0]   req_src1,
    input  logic [CORE_W-1:0]   req_src2,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [CORE_W-1:0]   resp_data,
    output logic                core_src_valid,
    input  logic                core_src_ready,
    output logic [CORE_W-1:0]   core_dividend,
    output logic [CORE_W-1:0]   core_divisor,
    output logic                core_res_ready,
    input  logic                core_res_valid,
    input  logic [2*CORE_W-1:0] core_res_data,
    output logic                busy
);
    import div_sched_pkg::*;

    logic [1:0]        r_state;
    logic              r_kill;
    div_ctx_t          r_ctx;
    logic [CORE_W-1:0] r_dividend;
    logic [CORE_W-1:0] r_divisor;
    logic [CORE_W-1:0] r_resp_data;

    logic              w_fire;
    logic              w_signed;
    logic [CORE_W-1:0] w_mag1;
    logic [CORE_W-1:0] w_mag2;
    logic              w_bypass;
    logic [CORE_W-1:0] w_bypass_data;
    logic [CORE_W-1:0] w_fix_data;

    assign req_ready      = (r_state == S_IDLE) & ~flush & ~r_kill;
    assign w_fire         = req_valid & req_ready;
    assign w_signed       = op_is_signed(req_op);

    assign core_src_valid = (r_state == S_ISSUE);
    assign core_res_ready = (r_state == S_WAIT);
    assign resp_valid     = (r_state == S_RESP);
    assign busy           = (r_state != S_IDLE);
    assign core_dividend  = r_dividend;
    assign core_divisor   = r_divisor;
    assign resp_data      = r_resp_data;

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass      = (req_src2 == '0);
`else
    assign w_bypass      = 1'b0;
`endif
    assign w_bypass_data = op_is_rem(req_op) ? req_src1 : '1;

    // Operand magnitudes; -2^(W-1) wraps onto itself, which the core reads as 2^(W-1)
    always_comb begin
        w_mag1 = (w_signed && req_src1[CORE_W-1]) ? -req_src1 : req_src1;
        w_mag2 = (w_signed && req_src2[CORE_W-1]) ? -req_src2 : req_src2;
    end

    div_sign_fix #(
        .W (CORE_W)
    ) u_sign_fix (
        .core_res  (core_res_data),
        .neg_q     (r_ctx.neg_q),
        .neg_r     (r_ctx.neg_r),
        .op        (r_ctx.op),
        .resp_data (w_fix_data)
    );

    // Sequencer: accept, issue to core, wait for result, hand back or drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_kill      <= 1'b0;
            r_ctx       <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_ctx.op    <= req_op;
                        r_ctx.neg_q <= w_signed & (req_src1[CORE_W-1] ^ req_src2[CORE_W-1]);
                        r_ctx.neg_r <= w_signed & req_src1[CORE_W-1];
                        r_dividend  <= w_mag1;
                        r_divisor   <= w_mag2;
                        if (w_bypass) begin
                            r_resp_data <= w_bypass_data;
                            r_state     <= S_RESP;
                        end else begin
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Operands stay valid until accepted even when killed
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (core_src_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_res_valid) begin
                        r_kill <= 1'b0;
                        if (r_kill || flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_resp_data <= w_fix_data;
                            r_state     <= S_RESP;
                        end
                    end else if (flush) begin
                        r_kill <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_div_sched
//  Description : Self-checking bench for div_sched with a behavioural divider
//                core, a reference model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sched;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_MOD  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_MODU = 2'b11;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, resp_ready;
    logic        core_src_ready, core_res_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic [63:0] core_res_data;
    logic        req_ready, resp_valid, core_src_valid, core_res_ready, busy;
    logic [31:0] resp_data, core_dividend, core_divisor;

    div_sched #(.CORE_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_src1       (req_src1),
        .req_src2       (req_src2),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .core_src_valid (core_src_valid),
        .core_src_ready (core_src_ready),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_res_ready (core_res_ready),
        .core_res_valid (core_res_valid),
        .core_res_data  (core_res_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    // core model knobs and observations
    int          core_lat  = 3;
    int          stall_cnt = 0;
    bit          rdy_rand  = 0;
    int          acc_cnt   = 0;
    int          acc_cyc   = -1;
    int          taken_cyc = -1;
    logic [31:0] acc_dd, acc_dv;

    // monitor observations
    int          n_resp   = 0;
    int          resp_cyc = -1;
    logic [31:0] last_resp;

    int          fire_cyc, t, idle_at, n0, k, flush_at, nw;
    logic [31:0] d0, ra, rb;
    logic [1:0]  rop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Reference: signed ops use truncating integer division, unsigned plain.
    // A zero divisor follows the bench core (quotient all ones, remainder =
    // dividend magnitude) and then the sign rules, unless bypassed.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
`ifdef DIV_ZERO_BYPASS_EN
        if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
`endif
        if (op[1]) begin
            if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
            return op[0] ? (a % b) : (a / b);
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = a[31] ? 64'sd1 : 64'sd4294967295;   // -(2^32-1) wraps to 1
            r = sa;                                 // -|a| equals a
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[0] ? 32'(r) : 32'(q);
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Behavioural unsigned divider core with fixed latency after acceptance
    initial begin
        int cnt  = 0;
        bit pend = 0;
        bit take = 0;
        core_src_ready = 1'b1;
        core_res_valid = 1'b0;
        core_res_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (take) core_res_valid = 1'b0;
            if (pend && !core_res_valid) begin
                cnt--;
                if (cnt == 0) core_res_valid = 1'b1;
            end
            core_src_ready = (stall_cnt > 0) ? 1'b0 : (rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
            #3;
            take = core_res_valid & core_res_ready;
            if (rst) begin
                take = 1'b1;
                pend = 1'b0;
            end else begin
                if (take) begin
                    pend      = 1'b0;
                    taken_cyc = cyc;
                end
                if (core_src_valid && !core_src_ready && stall_cnt > 0) stall_cnt--;
                if (core_src_valid && core_src_ready) begin
                    acc_cnt++;
                    acc_cyc = cyc;
                    acc_dd  = core_dividend;
                    acc_dv  = core_divisor;
                    pend    = 1'b1;
                    cnt     = core_lat;
                    core_res_data = (core_divisor == 32'd0) ? {32'hFFFF_FFFF, core_dividend}
                                  : {core_dividend / core_divisor, core_dividend % core_divisor};
                end
            end
        end
    end

    // Monitor: every response handshake pops and compares the scoreboard
    initial begin
        forever begin
            @(posedge clk); #4;
            if (!rst && resp_valid && resp_ready) begin
                n_resp++;
                resp_cyc  = cyc;
                last_resp = resp_data;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got 0x%08h, expected no response", resp_data);
                end else begin
                    check("resp_data", resp_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one request until it fires; expectation pushed at the fire point
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        #3;
        while (!req_ready && n < 100) begin
            @(posedge clk); #4;
            n++;
        end
        if (!req_ready) begin
            fail_now("issue");
        end else begin
            exp_q.push_back(ref_div(op, a, b));
            fire_cyc = cyc;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int at);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (busy) fail_now("wait_idle");
        at = cyc;
    endtask

    // One-cycle flush; an op in flight at that moment yields no response
    task automatic do_flush();
        logic rr;
        rr         = resp_ready;
        resp_ready = 1'b0;
        flush      = 1'b1;
        if (busy && exp_q.size() > 0) exp_q.delete(0);
        tick();
        flush      = 1'b0;
        resp_ready = rr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_src1 = '0; req_src2 = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_core_src_valid", 32'(core_src_valid), 0);
        check("rst_core_res_ready", 32'(core_res_ready), 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        check("idle_req_ready", 32'(req_ready), 1);
        tick();

        // divu 100/7 with a 10-cycle core
        core_lat = 10;
        issue(OP_DIVU, 32'd100, 32'd7);
        t = fire_cyc;
        wait_idle(idle_at);
        check("divu_core_dividend", acc_dd, 32'd100);
        check("divu_core_divisor", acc_dv, 32'd7);
        check("divu_issue_cycle", acc_cyc - t, 1);
        check("divu_result", last_resp, 32'h0000_000E);
        check("divu_resp_latency", resp_cyc - t, 12);
        check("divu_idle_cycle", idle_at - t, 13);

        // signed -7 / 2
        core_lat = 3;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(idle_at);
        check("div_neg_dividend_mag", acc_dd, 32'd7);
        check("div_neg_divisor_mag", acc_dv, 32'd2);
        check("div_neg7_2", last_resp, 32'hFFFF_FFFD);
        issue(OP_MOD, 32'hFFFF_FFF9, 32'd2);
        wait_idle(idle_at);
        check("mod_neg7_2", last_resp, 32'hFFFF_FFFF);

        // most negative / -1
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(idle_at);
        check("min_dividend_mag", acc_dd, 32'h8000_0000);
        check("min_divisor_mag", acc_dv, 32'd1);
        check("div_min_m1", last_resp, 32'h8000_0000);
        issue(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(idle_at);
        check("mod_min_m1", last_resp, 32'd0);

        // source stall of 5 cycles, flush on the 2nd stalled cycle
        core_lat  = 4;
        stall_cnt = 5;
        n0 = n_resp;
        issue(OP_DIVU, 32'd50, 32'd5);
        t = fire_cyc;
        tick();
        do_flush();
        #3;
        check("kill_src_valid_held", 32'(core_src_valid), 1);
        check("kill_req_ready_low", 32'(req_ready), 0);
        tick();
        wait_idle(idle_at);
        check("kill_accept_cycle", acc_cyc - t, 6);
        check("kill_drain_cycle", taken_cyc - t, 10);
        check("kill_no_resp", n_resp - n0, 0);
        check("kill_idle_after_drain", idle_at - taken_cyc, 1);
        #3;
        check("kill_req_ready_back", 32'(req_ready), 1);
        tick();

        // response held for 3 cycles, then flushed in RESP
        core_lat   = 2;
        resp_ready = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd3);
        nw = 0;
        #3;
        while (!resp_valid && nw < 50) begin
            @(posedge clk); #4;
            nw++;
        end
        if (!resp_valid) fail_now("resp_wait");
        d0 = resp_data;
        check("hold_data", d0, 32'd333);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #4;
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_stable", resp_data, d0);
        end
        @(posedge clk); #1;
        do_flush();
        #3;
        check("resp_flush_valid", 32'(resp_valid), 0);
        check("resp_flush_busy", 32'(busy), 0);
        tick();
        resp_ready = 1'b1;

        // flush in IDLE refuses a request
        req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd9; req_src2 = 32'd3;
        flush = 1'b1;
        #3;
        check("idle_flush_ready", 32'(req_ready), 0);
        tick();
        req_valid = 1'b0;
        flush = 1'b0;
        #3;
        check("idle_flush_no_fire", 32'(busy), 0);
        tick();

        // reset mid-operation
        core_lat = 5;
        issue(OP_DIVU, 32'd77, 32'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        #3;
        check("midop_rst_busy", 32'(busy), 0);
        tick();

        // zero divisor
        n0 = acc_cnt;
        issue(OP_DIVU, 32'h0000_1234, 32'd0);
        t = fire_cyc;
        wait_idle(idle_at);
        check("zero_divu", last_resp, 32'hFFFF_FFFF);
`ifdef DIV_ZERO_BYPASS_EN
        check("zero_bypass_latency", resp_cyc - t, 1);
        issue(OP_MODU, 32'h0000_1234, 32'd0);
        wait_idle(idle_at);
        check("zero_modu", last_resp, 32'h0000_1234);
        check("zero_core_untouched", acc_cnt - n0, 0);
`else
        check("zero_core_used", acc_cnt - n0, 1);
`endif

        // randomized traffic with random stalls, backpressure and flushes
        rdy_rand = 1;
        for (int n = 0; n < 60; n++) begin
            core_lat = $urandom_range(1, 6);
            rop = 2'($urandom_range(0, 3));
            ra  = pick_val();
            rb  = pick_val();
            issue(rop, ra, rb);
            flush_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : -1;
            k = 0;
            while (busy && k < 300) begin
                if (k == flush_at) begin
                    do_flush();
                end else begin
                    resp_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                k++;
            end
            if (busy) fail_now("random_idle");
            resp_ready = 1'b1;
            check("scoreboard_drained", exp_q.size(), 0);
            exp_q.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
